// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA raster timing: pixel-rate divider, h/v counters, registered syncs,
// visible-area flag and per-pixel / per-frame strobes.
module vga_sync_gen #(
  parameter int DIV = 4,
  parameter int HD  = 640,
  parameter int HF  = 16,
  parameter int HR  = 96,
  parameter int HB  = 48,
  parameter int VD  = 480,
  parameter int VF  = 10,
  parameter int VR  = 2,
  parameter int VB  = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] pixel_x,
  output logic [8:0] pixel_y,
  output logic       video_on_out,
  output logic       hsync,
  output logic       vsync,
  output logic       p_tick,
  output logic       frame_tick
);

  localparam int HT = HD + HF + HR + HB;
  localparam int VT = VD + VF + VR + VB;
  localparam int HW = $clog2(HT);
  localparam int VW = 10;
  localparam int DW = $clog2(DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(HD);
  localparam logic [HW-1:0] H_SYNC_S = HW'(HD + HF);
  localparam logic [HW-1:0] H_SYNC_E = HW'(HD + HF + HR - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(VD);
  localparam logic [VW-1:0] V_SYNC_S = VW'(VD + VF);
  localparam logic [VW-1:0] V_SYNC_E = VW'(VD + VF + VR - 1);

  logic [DW-1:0] div_cnt;
  logic [HW-1:0] h_cnt;
  logic [HW-1:0] h_next;
  logic [VW-1:0] v_cnt;
  logic [VW-1:0] v_next;
  logic          h_end;
  logic          v_end;
  logic          hsync_q;
  logic          vsync_q;

  assign p_tick = (div_cnt == DIV_LAST);
  assign h_end  = (h_cnt == H_LAST);
  assign v_end  = (v_cnt == V_LAST);

  always_comb begin
    h_next = h_cnt + HW'(1);
    v_next = v_cnt;
    if (h_end) begin
      h_next = '0;
      v_next = v_end ? '0 : v_cnt + VW'(1);
    end
  end

  // Syncs are decoded from the next count so the flop output lines up with h_cnt/v_cnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_cnt <= p_tick ? '0 : div_cnt + DW'(1);
      if (p_tick) begin
        h_cnt   <= h_next;
        v_cnt   <= v_next;
        hsync_q <= !((h_next >= H_SYNC_S) && (h_next <= H_SYNC_E));
        vsync_q <= !((v_next >= V_SYNC_S) && (v_next <= V_SYNC_E));
      end
    end
  end

  assign pixel_x      = 10'(h_cnt);
  assign pixel_y      = v_cnt[8:0];
  assign video_on_out = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign frame_tick   = p_tick && h_end && v_end;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance for line/reset behaviour and a
// shrunken instance for whole-frame behaviour; per-pixel expectations via scoreboards.
module tb_vga_sync_gen;

  typedef struct {
    int         n;
    logic [9:0] x;
    logic [8:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ft;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_d = 1'b0;
  logic       rst_s = 1'b0;
  logic [9:0] px_d, px_s;
  logic [8:0] py_d, py_s;
  logic       von_d, von_s, hs_d, hs_s, vs_d, vs_s, pt_d, pt_s, ft_d, ft_s;

  int errs = 0;
  int checks = 0;
  int tick_d = 0;
  int tick_s = 0;
  exp_t q_d[$];
  exp_t q_s[$];
  exp_t e_d, e_s;

  always #5 clk = ~clk;

  vga_sync_gen dut_d (
    .clk(clk), .reset(rst_d), .pixel_x(px_d), .pixel_y(py_d), .video_on_out(von_d),
    .hsync(hs_d), .vsync(vs_d), .p_tick(pt_d), .frame_tick(ft_d)
  );

  vga_sync_gen #(
    .DIV(2), .HD(8), .HF(2), .HR(2), .HB(2), .VD(4), .VF(1), .VR(1), .VB(1)
  ) dut_s (
    .clk(clk), .reset(rst_s), .pixel_x(px_s), .pixel_y(py_s), .video_on_out(von_s),
    .hsync(hs_s), .vsync(vs_s), .p_tick(pt_s), .frame_tick(ft_s)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_d(input int n, input int x, input int y,
                        input bit hs, input bit vs, input bit von, input bit ft);
    exp_t e;
    e.n = n; e.x = 10'(x); e.y = 9'(y); e.hs = hs; e.vs = vs; e.von = von; e.ft = ft;
    q_d.push_back(e);
  endtask

  task automatic push_s(input int n, input int x, input int y,
                        input bit hs, input bit vs, input bit von, input bit ft);
    exp_t e;
    e.n = n; e.x = 10'(x); e.y = 9'(y); e.hs = hs; e.vs = vs; e.von = von; e.ft = ft;
    q_s.push_back(e);
  endtask

  // Monitors: the n-th p_tick since reset release is compared against any vector tagged n.
  always @(negedge clk) begin
    if (rst_d) tick_d = 0;
    else if (pt_d) begin
      if (q_d.size() != 0 && q_d[0].n == tick_d) begin
        e_d = q_d.pop_front();
        chk($sformatf("sb_d_tick%0d", e_d.n), {px_d, py_d, hs_d, vs_d, von_d, ft_d},
            {e_d.x, e_d.y, e_d.hs, e_d.vs, e_d.von, e_d.ft});
      end
      tick_d++;
    end
  end

  always @(negedge clk) begin
    if (rst_s) tick_s = 0;
    else if (pt_s) begin
      if (q_s.size() != 0 && q_s[0].n == tick_s) begin
        e_s = q_s.pop_front();
        chk($sformatf("sb_s_tick%0d", e_s.n), {px_s, py_s, hs_s, vs_s, von_s, ft_s},
            {e_s.x, e_s.y, e_s.hs, e_s.vs, e_s.von, e_s.ft});
      end
      tick_s++;
    end
  end

  localparam logic [24:0] RST_VAL = {10'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int found, first_pt, second_pt, hs_low, von_low, vs_low, ft_cnt, ft_k1, ft_k2;

    #1;
    rst_d = 1'b1;
    rst_s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_d", {px_d, py_d, hs_d, vs_d, pt_d, ft_d, von_d}, RST_VAL);
    chk("reset_s", {px_s, py_s, hs_s, vs_s, pt_s, ft_s, von_s}, RST_VAL);

    // Default timing: line 0 and the start of line 1
    push_d(0,    0,   0, 1, 1, 1, 0);
    push_d(1,    1,   0, 1, 1, 1, 0);
    push_d(639,  639, 0, 1, 1, 1, 0);
    push_d(640,  640, 0, 1, 1, 0, 0);
    push_d(655,  655, 0, 1, 1, 0, 0);
    push_d(656,  656, 0, 0, 1, 0, 0);
    push_d(751,  751, 0, 0, 1, 0, 0);
    push_d(752,  752, 0, 1, 1, 0, 0);
    push_d(799,  799, 0, 1, 1, 0, 0);
    push_d(800,  0,   1, 1, 1, 1, 0);
    push_d(1599, 799, 1, 1, 1, 0, 0);
    @(posedge clk);
    #1 rst_d = 1'b0;
    for (int i = 0; i < 10000 && q_d.size() != 0; i++) @(negedge clk);
    chk("drain_d_run1", q_d.size(), 0);

    // Reset mid-frame at pixel (700,2) inside the hsync pulse
    found = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (px_d == 10'd700 && py_d == 9'd2) begin
        found = 1;
        break;
      end
    end
    chk("find_700_2", found, 1);
    chk("hs_at_700", {hs_d, von_d}, 2'b00);
    rst_d = 1'b1;
    #1;
    chk("async_reset_d", {px_d, py_d, hs_d, vs_d, pt_d, ft_d, von_d}, RST_VAL);

    push_d(0,   0,   0, 1, 1, 1, 0);
    push_d(3,   3,   0, 1, 1, 1, 0);
    push_d(656, 656, 0, 0, 1, 0, 0);
    push_d(751, 751, 0, 0, 1, 0, 0);
    push_d(752, 752, 0, 1, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_d = 1'b0;
    first_pt = 0; second_pt = 0; hs_low = 0; von_low = 0;
    for (int k = 1; k <= 3200; k++) begin
      @(posedge clk);
      #1;
      if (pt_d) begin
        if (first_pt == 0) first_pt = k;
        else if (second_pt == 0) second_pt = k;
      end
      if (!hs_d) hs_low++;
      if (!von_d) von_low++;
    end
    chk("first_ptick_clk", first_pt, 3);
    chk("second_ptick_clk", second_pt, 7);
    chk("hsync_low_clks", hs_low, 384);
    chk("video_off_clks_line0", von_low, 640);
    for (int i = 0; i < 100 && q_d.size() != 0; i++) @(negedge clk);
    chk("drain_d_run2", q_d.size(), 0);

    // Shrunken timing: 14-pixel lines, 7-line frames, DIV=2
    push_s(0,   0,  0, 1, 1, 1, 0);
    push_s(7,   7,  0, 1, 1, 1, 0);
    push_s(8,   8,  0, 1, 1, 0, 0);
    push_s(10,  10, 0, 0, 1, 0, 0);
    push_s(11,  11, 0, 0, 1, 0, 0);
    push_s(12,  12, 0, 1, 1, 0, 0);
    push_s(14,  0,  1, 1, 1, 1, 0);
    push_s(56,  0,  4, 1, 1, 0, 0);
    push_s(70,  0,  5, 1, 0, 0, 0);
    push_s(83,  13, 5, 1, 0, 0, 0);
    push_s(84,  0,  6, 1, 1, 0, 0);
    push_s(97,  13, 6, 1, 1, 0, 1);
    push_s(98,  0,  0, 1, 1, 1, 0);
    push_s(195, 13, 6, 1, 1, 0, 1);
    @(posedge clk);
    #1 rst_s = 1'b0;
    vs_low = 0; ft_cnt = 0; ft_k1 = 0; ft_k2 = 0;
    for (int k = 1; k <= 392; k++) begin
      @(posedge clk);
      #1;
      if (!vs_s) vs_low++;
      if (ft_s) begin
        ft_cnt++;
        if (ft_k1 == 0) ft_k1 = k;
        else if (ft_k2 == 0) ft_k2 = k;
      end
    end
    chk("s_vsync_low_clks", vs_low, 56);
    chk("s_frame_tick_count", ft_cnt, 2);
    chk("s_frame_tick_first", ft_k1, 195);
    chk("s_frame_period", ft_k2 - ft_k1, 196);
    for (int i = 0; i < 100 && q_s.size() != 0; i++) @(negedge clk);
    chk("drain_s", q_s.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
